// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: hold-FSM encoding and
// constant-width helpers used to size per-channel counters.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    HOLD     = 2'd1,
    REPEAT   = 2'd2
  } hold_state_e;

  // Ceiling log2, never below 1 so the result can always size a vector.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, tick-based debounce, typematic hold FSM
// and the registered press/release/repeat pulses.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RELEASED | debounced level low, hold counter idle
//   HOLD     | pressed, counting ticks toward the first repeat
//   REPEAT   | pressed past the initial delay, repeating every RATE ticks
module debounce_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 8,
  parameter int REPEAT_RATE    = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic tick_en,
  input  logic inp,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic any_next
);

  localparam int CW = clog2(DEBOUNCE_TICKS);
  localparam int HW = clog2(max2(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] DELAY_LAST = HW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);
  localparam bit            REPEAT_EN  = (REPEAT_DELAY > 0);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;
  logic [HW-1:0]          hcnt;
  hold_state_e            state;
  logic                   flip;
  logic                   rise;
  logic                   fall;
  logic                   rep_hit;

  assign s = sync[SYNC_STAGES-1];

  // A release on the same tick as a due repeat suppresses the repeat.
  always_comb begin
    flip    = tick_en && (s != level) && (cnt == CNT_LAST);
    rise    = flip && s;
    fall    = flip && !s;
    rep_hit = 1'b0;
    if (REPEAT_EN && tick_en && !fall) begin
      case (state)
        HOLD:    rep_hit = (hcnt == DELAY_LAST);
        REPEAT:  rep_hit = (hcnt == RATE_LAST);
        default: rep_hit = 1'b0;
      endcase
    end
    any_next = rise || rep_hit;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync          <= '0;
      cnt           <= '0;
      hcnt          <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      state         <= RELEASED;
    end else begin
      sync          <= {sync[SYNC_STAGES-2:0], inp};
      press_pulse   <= rise;
      release_pulse <= fall;
      repeat_pulse  <= rep_hit;

      if (tick_en) begin
        if (s != level) begin
          if (cnt == CNT_LAST) begin
            level <= s;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end

      case (state)
        RELEASED: begin
          if (rise) begin
            state <= HOLD;
            hcnt  <= '0;
          end
        end
        HOLD, REPEAT: begin
          if (fall) begin
            state <= RELEASED;
            hcnt  <= '0;
          end else if (tick_en && REPEAT_EN) begin
            if (rep_hit) begin
              state <= REPEAT;
              hcnt  <= '0;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
        end
        default: begin
          state <= RELEASED;
          hcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: N_CH independent debounce channels plus a
// registered OR of every press and repeat pulse.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 8,
  parameter int REPEAT_RATE    = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            tick_en,
  input  logic [N_CH-1:0] inp,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            any_press
);

  logic [N_CH-1:0] any_next;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE)
    ) u_ch (
      .clk          (clk),
      .clr          (clr),
      .tick_en      (tick_en),
      .inp          (inp[gi]),
      .level        (level[gi]),
      .press_pulse  (press_pulse[gi]),
      .release_pulse(release_pulse[gi]),
      .repeat_pulse (repeat_pulse[gi]),
      .any_next     (any_next[gi])
    );
  end

  // Built from the channels' next-pulse terms so it lines up with the pulses.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) any_press <= 1'b0;
    else     any_press <= |any_next;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// traffic, all compared against a tick-counting behavioural model.
module tb_button_conditioner;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int RD   = 8;
  localparam int RR   = 4;
  localparam int W    = 4 * N + 1;

  logic         clk = 1'b0;
  logic         clr;
  logic         tick_en;
  logic [N-1:0] inp;
  logic [N-1:0] level, press_pulse, release_pulse, repeat_pulse;
  logic         any_press;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: input delay line, consecutive-disagree tick count, ticks since press.
  logic [SYNC-1:0] m_sh [N];
  int              m_run [N];
  int              m_held [N];
  bit              m_active [N];
  logic [N-1:0]    m_level, m_press, m_rel, m_rep;
  logic            m_any;

  button_conditioner #(
    .N_CH(N), .SYNC_STAGES(SYNC), .DEBOUNCE_TICKS(DEB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .tick_en      (tick_en),
    .inp          (inp),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .any_press    (any_press)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dut_vec();
    return {level, press_pulse, release_pulse, repeat_pulse, any_press};
  endfunction

  function automatic logic [W-1:0] model_vec();
    return {m_level, m_press, m_rel, m_rep, m_any};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_sh[c] = '0; m_run[c] = 0; m_held[c] = 0; m_active[c] = 0;
    end
    m_level = '0; m_press = '0; m_rel = '0; m_rep = '0; m_any = 1'b0;
  endtask

  task automatic model_step();
    if (clr) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N; c++) begin
      logic sv;
      sv = m_sh[c][SYNC-1];
      m_press[c] = 1'b0; m_rel[c] = 1'b0; m_rep[c] = 1'b0;
      if (tick_en) begin
        if (sv != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_level[c] = sv;
            m_run[c]   = 0;
            if (sv) m_press[c] = 1'b1;
            else    m_rel[c]   = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      if (m_press[c]) begin
        m_active[c] = 1; m_held[c] = 0;
      end else if (m_rel[c]) begin
        m_active[c] = 0; m_held[c] = 0;
      end else if (m_active[c] && tick_en && RD > 0) begin
        m_held[c]++;
        if (m_held[c] >= RD && ((m_held[c] - RD) % RR) == 0) m_rep[c] = 1'b1;
      end
      m_sh[c] = {m_sh[c][SYNC-2:0], inp[c]};
    end
    m_any = |(m_press | m_rep);
  endtask

  // Advance one clock; leaves the caller at the following falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_idle_track(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cycle();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL %s_model cyc %0d: got %h expected %h", tag, i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; tick_en = 1'b1; inp = '0;
    model_reset();
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if (dut_vec() !== '0) begin
      n_fail++; $display("FAIL reset_async: got %h expected 0", dut_vec());
    end
    inp = '1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (dut_vec() !== '0) begin
        n_fail++; $display("FAIL reset_held cyc %0d: got %h expected 0", i, dut_vec());
      end
    end
    inp = '0;
    cycle();
    clr = 1'b0;
    test_idle_track(10, "reset_release");
  endtask

  task automatic test_clean_press();
    inp = 4'b0001;
    for (int e = 1; e <= 12; e++) begin
      cycle();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL clean_model e%0d: got %h expected %h", e, dut_vec(), model_vec());
      end
      n_checks++;
      if (level[0] !== (e >= 6)) begin
        n_fail++; $display("FAIL clean_level e%0d: got %b expected %b", e, level[0], (e >= 6));
      end
      n_checks++;
      if (press_pulse[0] !== (e == 6)) begin
        n_fail++; $display("FAIL clean_press e%0d: got %b expected %b", e, press_pulse[0], (e == 6));
      end
      n_checks++;
      if ({level[3:1], press_pulse[3:1]} !== 6'b0) begin
        n_fail++; $display("FAIL clean_others e%0d: got %b expected 0", e, {level[3:1], press_pulse[3:1]});
      end
    end
    inp = '0;
    test_idle_track(30, "clean_release");
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    pat = 4'b0101;
    for (int p = 0; p < 5; p++) begin
      inp[1] = (p < 4) ? pat[p] : 1'b0;
      for (int k = 0; k < ((p < 4) ? 3 : 20); k++) begin
        cycle();
        n_checks++;
        if (dut_vec() !== model_vec()) begin
          n_fail++; $display("FAIL bounce_model p%0d k%0d: got %h expected %h", p, k, dut_vec(), model_vec());
        end
        n_checks++;
        if ({level[1], press_pulse[1], release_pulse[1]} !== 3'b000) begin
          n_fail++; $display("FAIL bounce_ch1 p%0d k%0d: got %b expected 000", p, k,
                             {level[1], press_pulse[1], release_pulse[1]});
        end
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic exp_rep;
    inp = 4'b0100;
    for (int e = 1; e <= 44; e++) begin
      cycle();
      exp_rep = (e >= 14 && e < 34 && ((e - 14) % 4) == 0);
      n_checks++;
      if (repeat_pulse[2] !== exp_rep) begin
        n_fail++; $display("FAIL repeat_pulse e%0d: got %b expected %b", e, repeat_pulse[2], exp_rep);
      end
      n_checks++;
      if (release_pulse[2] !== (e == 34)) begin
        n_fail++; $display("FAIL repeat_release e%0d: got %b expected %b", e, release_pulse[2], (e == 34));
      end
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL repeat_model e%0d: got %h expected %h", e, dut_vec(), model_vec());
      end
      if (e == 28) inp = '0;
    end
  endtask

  task automatic test_prescaled();
    int press_cycles;
    press_cycles = 0;
    inp = 4'b1000;
    for (int cyc = 0; cyc < 150; cyc++) begin
      tick_en = ((cyc % 10) == 0);
      cycle();
      if (press_pulse[3]) press_cycles++;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL prescale_model c%0d: got %h expected %h", cyc, dut_vec(), model_vec());
      end
      if (cyc < 60) begin
        n_checks++;
        if ({level[3], press_pulse[3]} !== {1'(cyc >= 40), 1'(cyc == 40)}) begin
          n_fail++; $display("FAIL prescale_level c%0d: got %b expected %b", cyc,
                             {level[3], press_pulse[3]}, {1'(cyc >= 40), 1'(cyc == 40)});
        end
      end
    end
    n_checks++;
    if (press_cycles !== 1) begin
      n_fail++; $display("FAIL prescale_width: got %0d press cycles expected 1", press_cycles);
    end
    inp = '0; tick_en = 1'b1;
    test_idle_track(30, "prescale_release");
  endtask

  task automatic test_reset_mid_hold();
    inp = 4'b1000;
    test_idle_track(24, "midhold_run");
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if (dut_vec() !== '0) begin
      n_fail++; $display("FAIL midhold_async: got %h expected 0", dut_vec());
    end
    model_reset();
    cycle();
    cycle();
    clr = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      cycle();
      n_checks++;
      if (press_pulse[3] !== (e == 6)) begin
        n_fail++; $display("FAIL midhold_press e%0d: got %b expected %b", e, press_pulse[3], (e == 6));
      end
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL midhold_model e%0d: got %h expected %h", e, dut_vec(), model_vec());
      end
    end
    inp = '0;
    test_idle_track(30, "midhold_release");
  endtask

  task automatic test_simultaneous();
    inp = '1;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      n_checks++;
      if ({press_pulse, any_press} !== ((e == 6) ? {4'hF, 1'b1} : 5'b0)) begin
        n_fail++; $display("FAIL simul_press e%0d: got %b expected %b", e, {press_pulse, any_press},
                           ((e == 6) ? {4'hF, 1'b1} : 5'b0));
      end
    end
    inp = '0;
    test_idle_track(30, "simul_release");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) inp[$urandom_range(0, N - 1)] ^= 1'b1;
      tick_en = ($urandom_range(0, 3) != 0);
      cycle();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL random_model i%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    inp = '0; tick_en = 1'b1;
    test_idle_track(40, "random_drain");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_idle_track(20, "gap");
    test_prescaled();
    test_reset_mid_hold();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Multi-channel successor to the single-input one-shot pulse block.
- Each channel synchronises a raw button/switch input, debounces it over a programmable number of sample ticks, and emits a debounced level plus single-clock press and release pulses.
- Each channel also emits a typematic auto-repeat pulse while the button is held.
- Sits between board push-buttons/switches and control FSMs, for example VGA cursor movement and mode selection.

Parameters:
- N_CH, 4, number of independent input channels (≥1).
- SYNC_STAGES, 2, synchroniser flops per channel (≥2).
- DEBOUNCE_TICKS, 4, consecutive disagreeing sample ticks required to flip the level (≥1).
- REPEAT_DELAY, 8, ticks from press to first repeat pulse; 0 disables auto-repeat.
- REPEAT_RATE, 4, ticks between subsequent repeat pulses (≥1).

Ports:
- clk, in, 1, system clock.
- clr, in, 1, reset, asynchronous, active-high.
- tick_en, in, 1, sample strobe (single-clk pulse from a prescaler, or tied high).
- inp, in, N_CH, raw asynchronous button inputs.
- level, out, N_CH, debounced level.
- press_pulse, out, N_CH, one-clk pulse on debounced 0→1.
- release_pulse, out, N_CH, one-clk pulse on debounced 1→0.
- repeat_pulse, out, N_CH, one-clk auto-repeat pulse while held.
- any_press, out, 1, OR of press_pulse | repeat_pulse.

Behaviour:
- Reset: clr=1 asynchronously clears all synchroniser flops, counters, level, pulses and any_press to 0, and sets every FSM to RELEASED. Reset mid-debounce or mid-hold discards all progress; no pulse is generated on reset release.
- Synchroniser: s[i] is the last of the SYNC_STAGES flops, clocked every clk, independent of tick_en.
- Debounce counter cnt[i] has width clog2(DEBOUNCE_TICKS), min 1. On a clk edge with tick_en=1:
  - if s≠level and cnt==DEBOUNCE_TICKS-1: level<=s, cnt<=0, and the matching press/release pulse <=1;
  - else if s≠level: cnt<=cnt+1;
  - else (s==level): cnt<=0, so a bounce shorter than DEBOUNCE_TICKS ticks is fully rejected.
- tick_en=0: cnt and hcnt hold their values; the synchroniser still shifts.
- Pulses are registered and high for exactly one clk, then return to 0 on the next edge regardless of tick_en.
- Latency with tick_en tied high: level changes SYNC_STAGES+DEBOUNCE_TICKS clk edges after the first edge sampling the new inp value. The pulse is high in the cycle immediately after level changes.
- Per-channel hold FSM, hold counter hcnt width clog2(max(REPEAT_DELAY,REPEAT_RATE)):
  - RELEASED: on debounced rise → HOLD, hcnt<=0.
  - HOLD: on a tick, if hcnt==REPEAT_DELAY-1 → repeat_pulse<=1, hcnt<=0, go to REPEAT; else hcnt++.
  - REPEAT: on a tick, if hcnt==REPEAT_RATE-1 → repeat_pulse<=1, hcnt<=0; else hcnt++.
  - HOLD/REPEAT: a debounced fall → RELEASED, hcnt<=0, and no repeat pulse on that edge (release takes priority).
  - REPEAT_DELAY=0: the FSM stays in HOLD and repeat_pulse is never asserted.
- The press edge itself produces press_pulse only, never repeat_pulse.
- Channels are fully independent. Simultaneous events on several channels each pulse in the same cycle; any_press is the registered OR (same cycle as the pulses).

Decomposition:
- Shared package btn_pkg: hold-FSM state encoding (RELEASED=2'd0, HOLD=2'd1, REPEAT=2'd2) and a clog2 constant function.
- One sub-module, debounce_channel: synchroniser, debounce counter, hold FSM and the three pulses for one channel.
- button_conditioner instantiates N_CH copies via generate and builds the any_press OR.

Test Plan:
- Clean press, defaults, tick_en=1: inp[0] 0→1 before edge 1 → level[0]=1 after edge 6; press_pulse[0] high for exactly cycle 6–7; other channels stay 0.
- Bounce rejection: inp[1] toggles 1,0,1,0 with each value held 3 clks (<4 ticks), then returns to 0 → level[1] never rises; no press/release pulses.
- Auto-repeat: hold inp[2]=1 with press at edge 6 → repeat_pulse[2] after edges 14, 18, 22, …; release → release_pulse once and no further repeats.
- Prescaled ticks: tick_en every 10th clk, hold inp[3] → level rises only after 4 ticks following synchronisation; counters hold between ticks; pulses remain 1 clk wide.
- Reset mid-hold: assert clr asynchronously during REPEAT → all outputs 0 immediately. After clr drops with inp still 1, a fresh press_pulse appears after 6 edges.
- Simultaneous: all inp rise together → all press_pulse bits and any_press high in the same single cycle.
